// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter slice.
// Latency: n/a (declarations only). Backpressure: n/a.
package mem_arb_pkg;

    // RISC-V load/store size codes carried on funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int MAX_CH      = 8;
    localparam int MAX_CH_ID_W = 3;

    // A single channel still needs one bit of id so vectors never collapse to zero width.
    function automatic int ch_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [MAX_CH_ID_W-1:0] chan_id;
    } ret_entry_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory arbiter: per-channel requests plus shared read return.
// Latency: n/a (wiring only). Backpressure: req_ready per channel, responses are never stalled.
interface mem_port_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_we;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH*3-1:0]      req_func3;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_func3,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_func3,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/rr_arbiter.sv
// Picks one requesting channel per cycle: round-robin, or strict low-index priority with FIXED_PRIO_EN.
// Latency: combinational grant; pointer moves on the edge after an accepted grant.
// Backpressure: channels not granted simply wait; no grant when nothing is valid.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ID_W   = ch_id_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_vld,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [ID_W-1:0]   grant_idx
);

`ifdef FIXED_PRIO_EN

    logic unused_rr_inputs;
    assign unused_rr_inputs = ^{clk, rst, advance};

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_vld[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

`else

    logic [ID_W-1:0] ptr;
    logic            found;
    int              cand;

    // Pointer starts at the last channel so channel 0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= ID_W'(NUM_CH - 1);
        else if (advance)
            ptr <= grant_idx;
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = (int'(ptr) + k) % NUM_CH;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && (i == cand) && req_vld[i]) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = ID_W'(i);
                end
            end
        end
    end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory among NUM_CH requesters; round-robin unless FIXED_PRIO_EN is defined.
// Latency: accept -> mem command 1 cycle, accept -> rsp_valid 1+RD_LAT cycles; one access per cycle.
// Backpressure: per-channel req_ready (one-hot); responses cannot be stalled by requesters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave req_bus,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int ID_W = ch_id_w(NUM_CH);

    logic [NUM_CH-1:0] req_vld;
    logic [NUM_CH-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_func3;

    logic [ID_W-1:0]   iss_id;
    ret_entry_t        ret_pipe [RD_LAT];
    ret_entry_t        ret_tail;

    // Requests presented during reset are never granted.
    assign req_vld = req_bus.req_valid & {NUM_CH{~rst}};

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept            = |grant;
    assign req_bus.req_ready = grant;

    always_comb begin
        sel_we    = req_bus.req_we[grant_idx];
        sel_addr  = req_bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
        sel_wdata = req_bus.req_wdata[grant_idx*DATA_W +: DATA_W];
        sel_func3 = req_bus.req_func3[grant_idx*3 +: 3];
    end

    // Issue stage: strobes follow accepts exactly; address/data hold between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_func3 <= '0;
            iss_id    <= '0;
        end else begin
            mem_read  <= accept & ~sel_we;
            mem_write <= accept & sel_we;
            if (accept) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_func3 <= sel_func3;
                iss_id    <= grant_idx;
            end
        end
    end

    // Return pipeline tracks which channel owns mem_rdata RD_LAT cycles after each read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++)
                ret_pipe[i] <= '0;
        end else begin
            ret_pipe[0] <= '{valid: mem_read, chan_id: MAX_CH_ID_W'(iss_id)};
            for (int i = 1; i < RD_LAT; i++)
                ret_pipe[i] <= ret_pipe[i-1];
        end
    end

    assign ret_tail          = ret_pipe[RD_LAT-1];
    assign req_bus.rsp_rdata = mem_rdata;

    always_comb begin
        req_bus.rsp_valid = '0;
        for (int i = 0; i < NUM_CH; i++)
            req_bus.rsp_valid[i] = ~rst & ret_tail.valid & (ret_tail.chan_id == MAX_CH_ID_W'(i));
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++)
            busy = busy | ret_pipe[i].valid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiter instances (RD_LAT 1, 2, 3) with one shared directed stimulus stream.
// Loads are scoreboarded per instance with data and exact response cycle.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NCH   = 2;
    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int NINST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [NCH-1:0]     req_valid;
    logic [NCH-1:0]     req_we;
    logic [NCH*AW-1:0]  req_addr;
    logic [NCH*DW-1:0]  req_wdata;
    logic [NCH*3-1:0]   req_func3;

    logic [NCH-1:0] ready_a  [NINST];
    logic [NCH-1:0] rspv_a   [NINST];
    logic [DW-1:0]  rdata_a  [NINST];
    logic [DW-1:0]  mwdata_a [NINST];
    logic [AW-1:0]  maddr_a  [NINST];
    logic [2:0]     mf3_a    [NINST];
    logic           mrd_a    [NINST];
    logic           mwr_a    [NINST];
    logic           busy_a   [NINST];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [6:0] a);
        return (a == 7'h10) ? 32'hDEADBEEF : {16'hC0DE, 9'd0, a};
    endfunction

    for (genvar g = 0; g < NINST; g++) begin : g_inst
        localparam int LAT = g + 1;

        mem_port_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

        logic          mem_read, mem_write, busy;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata, mem_rdata;
        logic [2:0]    mem_func3;
        logic [DW-1:0] mem  [128];
        logic [DW-1:0] rd_q [LAT];

        assign bus.req_valid = req_valid;
        assign bus.req_we    = req_we;
        assign bus.req_addr  = req_addr;
        assign bus.req_wdata = req_wdata;
        assign bus.req_func3 = req_func3;

        assign ready_a[g]  = bus.req_ready;
        assign rspv_a[g]   = bus.rsp_valid;
        assign rdata_a[g]  = bus.rsp_rdata;
        assign mwdata_a[g] = mem_wdata;
        assign maddr_a[g]  = mem_addr;
        assign mf3_a[g]    = mem_func3;
        assign mrd_a[g]    = mem_read;
        assign mwr_a[g]    = mem_write;
        assign busy_a[g]   = busy;

        mem_port_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
            .clk       (clk),
            .rst       (rst),
            .req_bus   (bus),
            .mem_read  (mem_read),
            .mem_write (mem_write),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_func3 (mem_func3),
            .mem_rdata (mem_rdata),
            .busy      (busy)
        );

        // Memory model: write on the strobe, read data appears LAT cycles after the address.
        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 128; i++)
                    mem[i] <= init_word(7'(i));
            end else if (mem_write) begin
                mem[mem_addr] <= mem_wdata;
            end
            rd_q[0] <= mem[mem_addr];
            for (int i = 1; i < LAT; i++)
                rd_q[i] <= rd_q[i-1];
        end
        assign mem_rdata = rd_q[LAT-1];
    end

    typedef struct {
        int          inst;
        int          ch;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load accepted this cycle: each instance must answer exactly 1+RD_LAT cycles later.
    task automatic push_load(input int ch, input logic [31:0] d);
        for (int g = 0; g < NINST; g++)
            sb.push_back('{inst: g, ch: ch, data: d, cyc: cyc + 2 + g});
    endtask

    task automatic sb_check();
        for (int g = 0; g < NINST; g++) begin
            int hit;
            hit = -1;
            for (int j = 0; j < sb.size(); j++)
                if (hit < 0 && sb[j].inst == g && sb[j].cyc == cyc)
                    hit = j;
            if (hit >= 0) begin
                chk($sformatf("rsp_valid i%0d c%0d", g, cyc), 32'(rspv_a[g]), 32'(2'b01 << sb[hit].ch));
                chk($sformatf("rsp_rdata i%0d c%0d", g, cyc), rdata_a[g], sb[hit].data);
                sb.delete(hit);
            end else begin
                chk($sformatf("rsp_quiet i%0d c%0d", g, cyc), 32'(rspv_a[g]), 32'd0);
            end
        end
    endtask

    task automatic neg_edge();
        @(negedge clk);
        sb_check();
    endtask

    task automatic pos_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            neg_edge();
            pos_edge();
        end
    endtask

    initial begin
        int          e;
        logic [6:0]  a;

        rst       = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_func3 = {F3_LW, F3_LW};

        // Reset with both channels requesting
        for (int c = 0; c < 2; c++) begin
            neg_edge();
            for (int g = 0; g < NINST; g++) begin
                chk($sformatf("rst_ready i%0d", g), 32'(ready_a[g]), 32'd0);
                chk($sformatf("rst_mem_read i%0d", g), 32'(mrd_a[g]), 32'd0);
                chk($sformatf("rst_mem_write i%0d", g), 32'(mwr_a[g]), 32'd0);
                chk($sformatf("rst_busy i%0d", g), 32'(busy_a[g]), 32'd0);
            end
            pos_edge();
        end
        rst       = 1'b0;
        req_valid = 2'b00;

        // Single load from channel 1
        req_valid = 2'b10;
        req_addr  = {7'h10, 7'h00};
        req_func3 = {F3_LW, F3_LB};
        neg_edge();
        for (int g = 0; g < NINST; g++)
            chk($sformatf("t2_ready i%0d", g), 32'(ready_a[g]), 32'(2'b10));
        push_load(1, 32'hDEADBEEF);
        pos_edge();
        req_valid = 2'b00;
        neg_edge();
        for (int g = 0; g < NINST; g++) begin
            chk($sformatf("t2_mem_read i%0d", g), 32'(mrd_a[g]), 32'd1);
            chk($sformatf("t2_mem_write i%0d", g), 32'(mwr_a[g]), 32'd0);
            chk($sformatf("t2_mem_addr i%0d", g), 32'(maddr_a[g]), 32'h10);
            chk($sformatf("t2_mem_func3 i%0d", g), 32'(mf3_a[g]), 32'(F3_LW));
        end
        pos_edge();
        idle(5);

        // Both channels requesting continuously
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {7'h21, 7'h20};
        for (int k = 0; k < 6; k++) begin
            neg_edge();
`ifdef FIXED_PRIO_EN
            e = 0;
`else
            e = k % 2;
`endif
            for (int g = 0; g < NINST; g++)
                chk($sformatf("t3_grant k%0d i%0d", k, g), 32'(ready_a[g]), 32'(2'b01 << e));
            push_load(e, init_word((e == 1) ? 7'h21 : 7'h20));
            pos_edge();
        end
        req_valid = 2'b00;
        idle(6);

        // Store from ch0 then load of the same word from ch1
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr  = {7'h05, 7'h05};
        req_wdata = {32'h0, 32'h12345678};
        neg_edge();
        for (int g = 0; g < NINST; g++)
            chk($sformatf("t4_store_ready i%0d", g), 32'(ready_a[g]), 32'(2'b01));
        pos_edge();
        req_valid = 2'b10;
        req_we    = 2'b00;
        neg_edge();
        for (int g = 0; g < NINST; g++) begin
            chk($sformatf("t4_load_ready i%0d", g), 32'(ready_a[g]), 32'(2'b10));
            chk($sformatf("t4_mem_write i%0d", g), 32'(mwr_a[g]), 32'd1);
            chk($sformatf("t4_mem_read i%0d", g), 32'(mrd_a[g]), 32'd0);
            chk($sformatf("t4_mem_addr i%0d", g), 32'(maddr_a[g]), 32'h05);
            chk($sformatf("t4_mem_wdata i%0d", g), mwdata_a[g], 32'h12345678);
        end
        push_load(1, 32'h12345678);
        pos_edge();
        req_valid = 2'b00;
        idle(5);

        // Four back-to-back loads alternating channels; busy watched on the RD_LAT=3 instance
        for (int k = 0; k < 9; k++) begin
            if (k < 4) begin
                e         = k % 2;
                a         = 7'h30 + 7'(k);
                req_valid = 2'(2'b01 << e);
                req_addr  = {a, a};
            end else begin
                req_valid = 2'b00;
            end
            neg_edge();
            if (k < 4) begin
                for (int g = 0; g < NINST; g++)
                    chk($sformatf("t5_ready k%0d i%0d", k, g), 32'(ready_a[g]), 32'(2'b01 << e));
                push_load(e, init_word(a));
            end
            if (k >= 2 && k <= 7)
                chk($sformatf("t5_busy_hi k%0d", k), 32'(busy_a[2]), 32'd1);
            if (k == 8)
                chk("t5_busy_lo", 32'(busy_a[2]), 32'd0);
            pos_edge();
        end

        // Reset one cycle after a read is issued: the read must vanish
        req_valid = 2'b01;
        req_addr  = {7'h40, 7'h40};
        neg_edge();
        for (int g = 0; g < NINST; g++)
            chk($sformatf("t6_ready i%0d", g), 32'(ready_a[g]), 32'(2'b01));
        pos_edge();
        req_valid = 2'b00;
        neg_edge();
        chk("t6_mem_read", 32'(mrd_a[1]), 32'd1);
        pos_edge();
        rst       = 1'b1;
        req_valid = 2'b11;
        neg_edge();
        for (int g = 0; g < NINST; g++)
            chk($sformatf("t6_rst_ready i%0d", g), 32'(ready_a[g]), 32'd0);
        pos_edge();
        rst       = 1'b0;
        req_valid = 2'b00;
        neg_edge();
        for (int g = 0; g < NINST; g++) begin
            chk($sformatf("t6_busy_after i%0d", g), 32'(busy_a[g]), 32'd0);
            chk($sformatf("t6_mem_read_after i%0d", g), 32'(mrd_a[g]), 32'd0);
        end
        pos_edge();
        idle(5);
        for (int g = 0; g < NINST; g++)
            chk($sformatf("t6_busy_end i%0d", g), 32'(busy_a[g]), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
